// File: rtl/sub_bytes_pkg.sv
// rtl/sub_bytes_pkg.sv - shared types and a reference S-box for the SubBytes sequencer
package sub_bytes_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ACK, ST_DONE} sb_state_t;

  localparam int NUM_BYTES = 16;

  typedef logic [3:0] byte_idx_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as v^254 in GF(2^8), then the AES affine map
  function automatic logic [7:0] sbox(input logic [7:0] v);
    logic [7:0] inv;
    logic [7:0] base;
    logic [7:0] e;
    inv  = 8'h01;
    base = v;
    e    = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gf_mul(inv, base);
      base = gf_mul(base, base);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/sub_bytes_sequencer.sv
// rtl/sub_bytes_sequencer.sv - walks a 128-bit state through a byte-wide S-box memory handshake
module sub_bytes_sequencer
  import sub_bytes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
)
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic [7:0]   addr,
  output logic         flag_address_sent,
  input  logic         flag_data_sent,
  input  logic [7:0]   data_in,
  output logic         data_ack,
  output logic         busy,
  output logic         error
);

  localparam byte_idx_t LAST_IDX = byte_idx_t'(NUM_BYTES - 1);

  sb_state_t   r_state;
  sb_state_t   w_next;
  logic [127:0] r_in;
  logic [127:0] r_result;
  byte_idx_t   r_idx;
  logic        w_timeout;
  logic        w_in_phase;
  logic [6:0]  w_base;

  assign w_base     = {~r_idx, 3'b000};
  assign w_in_phase = (r_state == ST_REQ) || (r_state == ST_ACK);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_next = ST_REQ;
      ST_REQ:  if (flag_data_sent) w_next = ST_ACK;
      ST_ACK:  if (!flag_data_sent) w_next = (r_idx == LAST_IDX) ? ST_DONE : ST_REQ;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (w_timeout) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_in     <= '0;
      r_result <= '0;
      r_idx    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_in  <= state_in;
          r_idx <= '0;
        end
        ST_REQ:  if (flag_data_sent) r_result[w_base +: 8] <= data_in;
        ST_ACK:  if (!flag_data_sent && r_idx != LAST_IDX) r_idx <= r_idx + 4'd1;
        default: ;
      endcase
      if (w_timeout) r_result <= '0;
    end
  end

`ifdef SUB_BYTES_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          r_error;

  assign w_timeout = w_in_phase && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign error     = r_error;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_error <= 1'b0;
    end else begin
      if (w_next != r_state) r_cnt <= '0;
      else if (w_in_phase)   r_cnt <= r_cnt + 1'b1;
      if (w_timeout)                          r_error <= 1'b1;
      else if (r_state == ST_IDLE && in_valid) r_error <= 1'b0;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign error     = 1'b0;
`endif

  assign in_ready          = (r_state == ST_IDLE);
  assign busy              = (r_state != ST_IDLE);
  assign flag_address_sent = (r_state == ST_REQ);
  assign data_ack          = (r_state == ST_ACK);
  assign out_valid         = (r_state == ST_DONE);
  assign addr              = w_in_phase ? r_in[w_base +: 8] : 8'h00;
  assign state_out         = r_result;

endmodule

// File: tb/tb_sub_bytes_sequencer.sv
// tb/tb_sub_bytes_sequencer.sv - randomized bench with a latency-configurable S-box memory model
module tb_sub_bytes_sequencer;

`ifdef SUB_BYTES_TIMEOUT_EN
  localparam int LAT_MAX = 5;
  localparam int TB_TIMEOUT = 8;
`else
  localparam int LAT_MAX = 10;
  localparam int TB_TIMEOUT = 255;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] state_in = '0;
  logic         flag_data_sent = 1'b0;
  logic [7:0]   data_in = 8'h00;
  logic         in_ready, out_valid, flag_address_sent, data_ack, busy, error;
  logic [127:0] state_out;
  logic [7:0]   addr;

  int n_tests = 0;
  int n_fail  = 0;

  int mem_lo = 1, mem_hi = 1;
  bit mem_dead = 1'b0;
  int mem_cnt = 0, cur_lat = 0, overlap = 0;
  logic [7:0] addr_q[$];

  always #5 clk = ~clk;

  sub_bytes_sequencer #(.TIMEOUT_CYCLES(TB_TIMEOUT)) u_dut (
    .clk(clk), .rst(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .state_in(state_in),
    .out_valid(out_valid), .out_ready(out_ready), .state_out(state_out),
    .addr(addr), .flag_address_sent(flag_address_sent),
    .flag_data_sent(flag_data_sent), .data_in(data_in),
    .data_ack(data_ack), .busy(busy), .error(error)
  );

  always @(negedge clk) begin
    if (flag_address_sent && data_ack) overlap++;
    if (!rst_n) begin
      flag_data_sent = 1'b0;
      mem_cnt = 0;
    end else if (!flag_data_sent) begin
      if (flag_address_sent) begin
        if (mem_cnt == 0) begin
          cur_lat = $urandom_range(mem_hi, mem_lo);
          addr_q.push_back(addr);
        end
        mem_cnt++;
        if (mem_cnt > cur_lat && !mem_dead) begin
          flag_data_sent = 1'b1;
          data_in = sub_bytes_pkg::sbox(addr);
          mem_cnt = 0;
        end
      end else mem_cnt = 0;
    end else begin
      if (data_ack) begin
        if (mem_cnt == 0) cur_lat = $urandom_range(mem_hi, mem_lo);
        mem_cnt++;
        if (mem_cnt > cur_lat) begin
          flag_data_sent = 1'b0;
          data_in = 8'($urandom);
          mem_cnt = 0;
        end
      end else mem_cnt = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = sub_bytes_pkg::sbox(s[8*k +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] pack_addrs();
    logic [127:0] p;
    p = '0;
    for (int k = 0; k < addr_q.size() && k < 16; k++) p[127-8*k -: 8] = addr_q[k];
    return p;
  endfunction

  task automatic run_block(input logic [127:0] st, input int hold,
                           output logic [127:0] res, output int cyc);
    int c;
    int stab_err;
    res = '0;
    cyc = 0;
    stab_err = 0;
    @(negedge clk);
    state_in = st;
    in_valid = 1'b1;
    c = 0;
    while (!in_ready && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (!in_ready) begin
      check_eq("accept_wait", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    addr_q.delete();
    @(negedge clk);
    in_valid = 1'b0;
    c = 1;
    while (!out_valid && c < 3000) begin
      @(negedge clk);
      c++;
    end
    cyc = c;
    if (!out_valid) begin
      check_eq("done_wait", 0, 1);
      return;
    end
    res = state_out;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (state_out !== res || in_ready !== 1'b0 || flag_address_sent !== 1'b0 || out_valid !== 1'b1)
        stab_err++;
    end
    if (hold > 0) check_eq("done_hold_stable", stab_err, 0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("ready_after_done", {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    logic [127:0] st, res;
    int cyc, c;
    bit seen_valid;

    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_outputs", {busy, out_valid, flag_address_sent, data_ack, error, addr, state_out}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in_ready", {in_ready, busy}, 2'b10);

    mem_lo = 1; mem_hi = 1;
    run_block('0, 0, res, cyc);
    check_eq("zero_state", res, {16{8'h63}});
    check_eq("zero_latency", cyc, 65);

    st = 128'h000102030405060708090a0b0c0d0e0f;
    run_block(st, 0, res, cyc);
    check_eq("seq_state", res, 128'h637c777bf26b6fc53001672bfed7ab76);
    check_eq("seq_addr_count", addr_q.size(), 16);
    check_eq("seq_addr_order", pack_addrs(), st);

    mem_lo = 1; mem_hi = LAT_MAX;
    overlap = 0;
    st = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    run_block(st, 0, res, cyc);
    check_eq("fips_state", res, 128'hd42711aee0bf98f1b8b45de51e415230);
    check_eq("fips_addr_order", pack_addrs(), st);
    check_eq("ack_req_overlap", overlap, 0);

    mem_lo = 1; mem_hi = 3;
    st = rand128();
    run_block(st, 20, res, cyc);
    check_eq("held_state", res, ref_sub(st));
    for (int b = 0; b < 2; b++) begin
      st = rand128();
      run_block(st, 0, res, cyc);
      check_eq("b2b_state", res, ref_sub(st));
    end

    mem_lo = 3; mem_hi = 3;
    st = rand128();
    @(negedge clk);
    state_in = st;
    in_valid = 1'b1;
    @(posedge clk);
    addr_q.delete();
    @(negedge clk);
    in_valid = 1'b0;
    c = 0;
    while (!(addr_q.size() == 8 && flag_address_sent) && c < 500) begin
      @(negedge clk);
      #1;
      c++;
    end
    check_eq("byte7_req_addr", {flag_address_sent, addr}, {1'b1, st[71:64]});
    rst_n = 1'b0;
    #1;
    check_eq("midrst_in_ready", in_ready, 1'b1);
    check_eq("midrst_outputs", {busy, out_valid, flag_address_sent, data_ack, error, addr, state_out}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    st = rand128();
    run_block(st, 0, res, cyc);
    check_eq("after_rst_state", res, ref_sub(st));

    mem_lo = 1; mem_hi = LAT_MAX;
    overlap = 0;
    for (int b = 0; b < 4; b++) begin
      st = rand128();
      run_block(st, $urandom_range(3, 0), res, cyc);
      check_eq("rand_state", res, ref_sub(st));
    end
    check_eq("rand_overlap", overlap, 0);

`ifdef SUB_BYTES_TIMEOUT_EN
    mem_dead = 1'b1;
    seen_valid = 1'b0;
    @(negedge clk);
    state_in = rand128();
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    c = 1;
    while (!error && c < 50) begin
      @(negedge clk);
      c++;
      if (out_valid) seen_valid = 1'b1;
    end
    check_eq("timeout_cycle", c, 9);
    check_eq("timeout_idle", {error, busy, in_ready, seen_valid, state_out}, {4'b1010, 128'h0});
    mem_dead = 1'b0;
    mem_lo = 1; mem_hi = 2;
    st = rand128();
    run_block(st, 0, res, cyc);
    check_eq("timeout_recover", res, ref_sub(st));
    check_eq("timeout_err_clr", error, 1'b0);
`else
    seen_valid = 1'b0;
    check_eq("error_tied", error, seen_valid);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sub_bytes_sequencer.md
# sub_bytes_sequencer

Feeds the byte-wide S-box lookup memory by walking a 128-bit AES state one byte at a time over the memory's address/data flag handshake. Collects the 16 substituted bytes and presents the full SubBytes result downstream. Sits between the round controller (128-bit valid/ready) and the S-box memory (8-bit flag handshake).

## Interface
- TIMEOUT_CYCLES, 255: max cycles spent waiting in one handshake phase before abort (used only with timeout feature)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  state_in valid
- in_ready  out  1  sequencer can accept a state
- state_in  in  128  input state; byte k = state_in[127-8k -: 8], byte 0 is the MSB
- out_valid  out  1  state_out valid
- out_ready  in  1  downstream accepts state_out
- state_out  out  128  substituted state, same byte order
- addr  out  8  S-box lookup address
- flag_address_sent  out  1  addr valid, request pending
- flag_data_sent  in  1  memory has driven data_in
- data_in  in  8  S-box result from memory
- data_ack  out  1  data captured, memory may release
- busy  out  1  not in IDLE
- error  out  1  sticky timeout flag, cleared by next acceptance

## Operation
- Registered FSM: IDLE, REQ, ACK, DONE. Outputs decoded from state/regs only; no combinational input-to-output path.
- IDLE: in_ready=1. On in_valid: latch state_in, idx=0, clear error, go REQ.
- REQ: flag_address_sent=1, addr=byte[idx]. On flag_data_sent=1: write data_in into result byte idx, go ACK.
- ACK: flag_address_sent=0, data_ack=1, addr holds. On flag_data_sent=0: if idx==15 go DONE, else idx+1, go REQ.
- DONE: out_valid=1, state_out stable. On out_ready: go IDLE. in_ready=0 in every state except IDLE.
- idx is 4 bits; increments only in ACK→REQ, never wraps within a block.
- flag_data_sent ignored in IDLE and DONE.
- Reset (any state, including mid-block): go IDLE; in_ready=1 after release; all other outputs 0; addr=0; state_out=0; idx=0; latched input discarded.

## Timing
- Accept on the edge where in_valid&&in_ready; REQ is active in the following cycle (cycle 1).
- Against a memory that raises flag_data_sent one cycle after seeing the request and drops it one cycle after data_ack: 4 cycles per byte (REQ 2, ACK 2); out_valid rises in cycle 65.
- Longer memory latency stretches REQ/ACK arbitrarily; ordering is unchanged.
- out_valid held, state_out constant, until out_ready; back-to-back blocks: next in_ready one cycle after the DONE handshake.

## Configuration
- SUB_BYTES_TIMEOUT_EN defined: cycle counter, cleared on each REQ/ACK entry, counts while in REQ or ACK. Reaching TIMEOUT_CYCLES sets error, drops flag_address_sent/data_ack, discards partial result, returns to IDLE (no out_valid).
- Undefined: no counter, error tied 0, waits indefinitely.

## Structure
- Package sub_bytes_pkg: FSM state enum, NUM_BYTES=16, byte-index typedef, reference sbox function for the bench.
- Single module; no sub-module needed.

## Test plan
- All-zero state, 1-cycle memory model -> state_out = 16×63; out_valid in cycle 65.
- state_in 000102030405060708090a0b0c0d0e0f -> 637c777bf26b6fc53001672bfed7ab76; addr sequence 00..0f in order.
- 193de3bea0f4e22b9ac68d2ae9f84808, random 1-10 cycle memory latency -> d42711aee0bf98f1b8b45de51e415230; data_ack never overlaps flag_address_sent.
- out_ready held low 20 cycles in DONE -> state_out stable, in_ready=0, no new addr; then two back-to-back blocks both correct.
- rst asserted during byte 7 REQ -> immediately IDLE, outputs 0; next block completes correctly.
- With SUB_BYTES_TIMEOUT_EN, TIMEOUT_CYCLES=8, memory never responds -> error=1 after 8 REQ cycles, return to IDLE, out_valid never asserted; error clears on next acceptance.
